// File: rtl/servo_cmd_rx_pkg.sv
// Shared constants and types for the servo command receiver: frame header,
// channel count, default timing and the receiver/parser state encodings.
package servo_cmd_rx_pkg;

  localparam logic [7:0] HDR_BYTE         = 8'hA5;
  localparam int         NUM_CH           = 3;
  localparam int         DEF_CLK_DIV      = 10416;
  localparam int         DEF_TIMEOUT_BITS = 20;

  typedef enum logic [1:0] {
    P_HDR  = 2'd0,
    P_CH   = 2'd1,
    P_DUTY = 2'd2,
    P_CHK  = 2'd3
  } parser_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // Frame check byte: channel index XOR duty value.
  function automatic logic [7:0] calc_chk(input logic [1:0] ch, input logic [7:0] duty);
    return {6'b000000, ch} ^ duty;
  endfunction

endpackage

// File: rtl/servo_cmd_rx_uart.sv
// 8N1 UART receiver: two-flop synchronizer, falling-edge start detect,
// half-bit start re-check, mid-bit data sampling and stop-bit framing check.
module uart_rx_8n1
  import servo_cmd_rx_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_byte,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int             CW        = $clog2(CLK_DIV);
  localparam logic [CW-1:0]  HALF_LAST = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0]  FULL_LAST = CW'(CLK_DIV - 1);

  logic      sync1_r, sync2_r, prev_r;
  rx_state_e state_r, state_nx_s;
  logic [CW-1:0] cnt_r, cnt_nx_s;
  logic [3:0] bit_cnt_r, bit_nx_s;
  logic [7:0] shift_r, shift_nx_s;
  logic valid_nx_s, ferr_nx_s;

  assign data_byte = shift_r;
  assign busy      = (state_r != RX_IDLE);

  // Bit timing: bit_cnt 0 = start, 1..8 = data, 9 = stop.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    bit_nx_s   = bit_cnt_r;
    shift_nx_s = shift_r;
    valid_nx_s = 1'b0;
    ferr_nx_s  = 1'b0;
    case (state_r)
      RX_IDLE: begin
        cnt_nx_s = '0;
        bit_nx_s = 4'd0;
        if (prev_r && !sync2_r) begin
          state_nx_s = RX_START;
        end else begin
          state_nx_s = RX_IDLE;
        end
      end
      RX_START: begin
        if (cnt_r == HALF_LAST) begin
          cnt_nx_s = '0;
          if (sync2_r) begin
            state_nx_s = RX_IDLE;
          end else begin
            state_nx_s = RX_DATA;
            bit_nx_s   = 4'd1;
          end
        end else begin
          cnt_nx_s = cnt_r + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_r == FULL_LAST) begin
          cnt_nx_s   = '0;
          shift_nx_s = {sync2_r, shift_r[7:1]};
          if (bit_cnt_r == 4'd8) begin
            bit_nx_s   = 4'd9;
            state_nx_s = RX_STOP;
          end else begin
            bit_nx_s = bit_cnt_r + 4'd1;
          end
        end else begin
          cnt_nx_s = cnt_r + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt_r == FULL_LAST) begin
          cnt_nx_s   = '0;
          bit_nx_s   = 4'd0;
          state_nx_s = RX_IDLE;
          if (sync2_r) begin
            valid_nx_s = 1'b1;
          end else begin
            ferr_nx_s = 1'b1;
          end
        end else begin
          cnt_nx_s = cnt_r + CW'(1);
        end
      end
      default: begin
        state_nx_s = RX_IDLE;
        cnt_nx_s   = '0;
        bit_nx_s   = 4'd0;
      end
    endcase
  end

  // Synchronizer, edge history and receiver state registers.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sync1_r    <= 1'b1;
      sync2_r    <= 1'b1;
      prev_r     <= 1'b1;
      state_r    <= RX_IDLE;
      cnt_r      <= '0;
      bit_cnt_r  <= 4'd0;
      shift_r    <= 8'h00;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync1_r    <= rx;
      sync2_r    <= sync1_r;
      prev_r     <= sync2_r;
      state_r    <= state_nx_s;
      cnt_r      <= cnt_nx_s;
      bit_cnt_r  <= bit_nx_s;
      shift_r    <= shift_nx_s;
      byte_valid <= valid_nx_s;
      frame_err  <= ferr_nx_s;
    end
  end

endmodule

// File: rtl/servo_cmd_rx.sv
// Servo command receiver: parses A5/CH/DUTY/CHK frames from a UART line and
// updates one of three registered PWM duty commands per valid frame.
module servo_cmd_rx
  import servo_cmd_rx_pkg::*;
#(
  parameter int CLK_DIV      = DEF_CLK_DIV,
  parameter int TIMEOUT_BITS = DEF_TIMEOUT_BITS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] duty_ch0,
  output logic [7:0] duty_ch1,
  output logic [7:0] duty_ch2,
  output logic       upd,
  output logic [1:0] upd_ch,
  output logic       err,
  output logic       busy
);

  localparam int TMO_LIMIT = TIMEOUT_BITS * CLK_DIV;
  localparam int TW        = $clog2(TMO_LIMIT);

  logic [7:0]    rx_byte_s;
  logic          byte_valid_s, frame_err_s, busy_s;
  parser_state_e p_state_r, p_nx_s;
  logic [1:0]    ch_r, ch_nx_s, upd_ch_nx_s;
  logic [7:0]    duty_lat_r, duty_nx_s;
  logic          upd_nx_s, err_nx_s, wr_s, tmo_hit_s;
  logic [TW-1:0] gap_r;

  uart_rx_8n1 #(.CLK_DIV(CLK_DIV)) u_uart (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .data_byte  (rx_byte_s),
    .byte_valid (byte_valid_s),
    .frame_err  (frame_err_s),
    .busy       (busy_s)
  );

  assign busy = busy_s;

  // gap_r counts elapsed idle cycles including the stop-sample cycle.
  assign tmo_hit_s = (p_state_r != P_HDR) && !busy_s && (gap_r == TW'(TMO_LIMIT - 1));

  // Inter-byte gap timer, reloaded while receiving or waiting for a header.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      gap_r <= '0;
    end else if ((p_state_r == P_HDR) || busy_s || tmo_hit_s) begin
      gap_r <= TW'(1);
    end else begin
      gap_r <= gap_r + TW'(1);
    end
  end

  // Frame parser: one transition per received byte; errors force a resync.
  always_comb begin
    p_nx_s      = p_state_r;
    ch_nx_s     = ch_r;
    duty_nx_s   = duty_lat_r;
    upd_ch_nx_s = upd_ch;
    upd_nx_s    = 1'b0;
    err_nx_s    = 1'b0;
    wr_s        = 1'b0;
    if (frame_err_s) begin
      err_nx_s = 1'b1;
      p_nx_s   = P_HDR;
    end else if (byte_valid_s) begin
      case (p_state_r)
        P_HDR: begin
          if (rx_byte_s == HDR_BYTE) begin
            p_nx_s = P_CH;
          end else begin
            p_nx_s = P_HDR;
          end
        end
        P_CH: begin
          if (rx_byte_s < 8'(NUM_CH)) begin
            ch_nx_s = rx_byte_s[1:0];
            p_nx_s  = P_DUTY;
          end else begin
            err_nx_s = 1'b1;
            p_nx_s   = P_HDR;
          end
        end
        P_DUTY: begin
          duty_nx_s = rx_byte_s;
          p_nx_s    = P_CHK;
        end
        P_CHK: begin
          p_nx_s = P_HDR;
          if (rx_byte_s == calc_chk(ch_r, duty_lat_r)) begin
            upd_nx_s    = 1'b1;
            upd_ch_nx_s = ch_r;
            wr_s        = 1'b1;
          end else begin
            err_nx_s = 1'b1;
          end
        end
        default: begin
          p_nx_s = P_HDR;
        end
      endcase
    end else if (tmo_hit_s) begin
      err_nx_s = 1'b1;
      p_nx_s   = P_HDR;
    end else begin
      p_nx_s = p_state_r;
    end
  end

  // Parser state and registered status outputs.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      p_state_r  <= P_HDR;
      ch_r       <= 2'd0;
      duty_lat_r <= 8'h00;
      upd        <= 1'b0;
      upd_ch     <= 2'd0;
      err        <= 1'b0;
    end else begin
      p_state_r  <= p_nx_s;
      ch_r       <= ch_nx_s;
      duty_lat_r <= duty_nx_s;
      upd        <= upd_nx_s;
      upd_ch     <= upd_ch_nx_s;
      err        <= err_nx_s;
    end
  end

  // Duty registers hold until their own channel is written.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      duty_ch0 <= 8'h00;
      duty_ch1 <= 8'h00;
      duty_ch2 <= 8'h00;
    end else if (wr_s) begin
      case (ch_r)
        2'd0:    duty_ch0 <= duty_lat_r;
        2'd1:    duty_ch1 <= duty_lat_r;
        2'd2:    duty_ch2 <= duty_lat_r;
        default: duty_ch0 <= duty_ch0;
      endcase
    end else begin
      duty_ch0 <= duty_ch0;
    end
  end

endmodule

// File: tb/tb_servo_cmd_rx.sv
// Scoreboard bench for servo_cmd_rx: stimulus queues expected upd/err events
// with their cycle numbers; a negedge monitor pops and compares them.
module tb_servo_cmd_rx;

  localparam int CLK_DIV      = 16;
  localparam int TIMEOUT_BITS = 20;
  // Cycle of the stop-bit sample relative to driving the start bit low:
  // 2 sync flops, half-bit start check, then nine full bit periods.
  localparam int STOP_OFS     = 2 + CLK_DIV / 2 + 9 * CLK_DIV;
  localparam int TMO_CYC      = TIMEOUT_BITS * CLK_DIV;

  typedef struct {
    int cyc;
    int ch;
    int duty;
  } upd_exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] duty_ch0, duty_ch1, duty_ch2;
  logic       upd, err, busy;
  logic [1:0] upd_ch;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  upd_exp_t upd_q[$];
  int       err_q[$];
  int       model[3];
  upd_exp_t mon_e;

  servo_cmd_rx #(.CLK_DIV(CLK_DIV), .TIMEOUT_BITS(TIMEOUT_BITS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .duty_ch0 (duty_ch0),
    .duty_ch1 (duty_ch1),
    .duty_ch2 (duty_ch2),
    .upd      (upd),
    .upd_ch   (upd_ch),
    .err      (err),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endfunction

  // Monitor: every upd/err the DUT presents must match the head of its queue.
  always @(negedge clk) begin
    if (rst_n) begin
      model = '{0, 0, 0};
    end else begin
      if (upd && err) check("upd_err_overlap", 1, 0);
      if (upd) begin
        if (upd_q.size() == 0) begin
          check("upd_unexpected", cyc, -1);
        end else begin
          mon_e = upd_q.pop_front();
          check("upd_cycle", cyc, mon_e.cyc);
          check("upd_ch", int'(upd_ch), mon_e.ch);
          model[mon_e.ch] = mon_e.duty;
        end
        check("duty_ch0", int'(duty_ch0), model[0]);
        check("duty_ch1", int'(duty_ch1), model[1]);
        check("duty_ch2", int'(duty_ch2), model[2]);
      end
      if (err) begin
        if (err_q.size() == 0) check("err_unexpected", cyc, -1);
        else check("err_cycle", cyc, err_q.pop_front());
      end
    end
  end

  // Called #1 after a posedge; returns #1 after the posedge ending the stop bit.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (CLK_DIV) @(posedge clk);
      #1;
    end
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input bit expect_upd);
    upd_exp_t e;
    send_byte(b0, 1'b1);
    send_byte(b1, 1'b1);
    send_byte(b2, 1'b1);
    if (expect_upd) begin
      e.cyc = cyc + STOP_OFS + 2;
      e.ch = int'(b1);
      e.duty = int'(b2);
      upd_q.push_back(e);
    end else begin
      err_q.push_back(cyc + STOP_OFS + 2);
    end
    send_byte(b3, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_duty_ch0"}, int'(duty_ch0), 0);
    check({tag, "_duty_ch1"}, int'(duty_ch1), 0);
    check({tag, "_duty_ch2"}, int'(duty_ch2), 0);
    check({tag, "_upd"}, int'(upd), 0);
    check({tag, "_upd_ch"}, int'(upd_ch), 0);
    check({tag, "_err"}, int'(err), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    repeat (4) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    send_frame(8'hA5, 8'h01, 8'h80, 8'h81, 1'b1);
    send_frame(8'hA5, 8'h02, 8'h40, 8'h00, 1'b0);
    send_frame(8'hA5, 8'h02, 8'h40, 8'h42, 1'b1);

    // Out-of-range channel byte.
    send_byte(8'hA5, 1'b1);
    err_q.push_back(cyc + STOP_OFS + 2);
    send_byte(8'h03, 1'b1);

    // Framing error: stop bit held low, then line released.
    err_q.push_back(cyc + STOP_OFS + 2);
    send_byte(8'h55, 1'b0);
    repeat (20) @(posedge clk);
    #1;

    // Short low glitch: start bit rejected at the half-bit check.
    rx = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rx = 1'b1;
    check("glitch_busy_high", int'(busy), 1);
    repeat (7) @(posedge clk);
    #1;
    check("glitch_busy_low", int'(busy), 0);
    repeat (30) @(posedge clk);
    #1;

    // Header value as duty data.
    send_frame(8'hA5, 8'h01, 8'hA5, 8'hA4, 1'b1);

    // Inter-byte timeout, then a fresh frame proves the parser resynced.
    send_byte(8'hA5, 1'b1);
    err_q.push_back(cyc + STOP_OFS + TMO_CYC);
    send_byte(8'h01, 1'b1);
    repeat (400) @(posedge clk);
    #1;
    send_frame(8'hA5, 8'h00, 8'h11, 8'h11, 1'b1);

    // Reset in the middle of the duty byte.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    rx = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("midreset");
    rst_n = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    send_frame(8'hA5, 8'h02, 8'h33, 8'h31, 1'b1);

    // Back-to-back frames with no idle gap.
    send_frame(8'hA5, 8'h00, 8'hFF, 8'hFF, 1'b1);
    send_frame(8'hA5, 8'h02, 8'h00, 8'h02, 1'b1);

    repeat (50) @(posedge clk);
    #1;
    check("upd_queue_drained", upd_q.size(), 0);
    check("err_queue_drained", err_q.size(), 0);
    check("final_duty_ch0", int'(duty_ch0), 8'hFF);
    check("final_duty_ch1", int'(duty_ch1), 0);
    check("final_duty_ch2", int'(duty_ch2), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
